// File: rtl/clock_pkg.sv
// Shared widths, limits and FSM state type for the clock time-set path.
package clock_pkg;

  localparam int unsigned HOURS_W    = 5;
  localparam int unsigned MINUTES_W  = 6;
  localparam int unsigned MAX_HOUR   = 23;
  localparam int unsigned MAX_MINUTE = 59;
  localparam int unsigned FIELD_W    = 7;

  typedef enum logic [1:0] {
    IDLE,
    EDIT_HOUR,
    EDIT_MIN,
    COMMIT
  } setter_state_t;

  // Wrap check happens before the add/sub so out-of-range values snap back into range.
  function automatic logic [FIELD_W-1:0] wrap_step(input logic [FIELD_W-1:0] value,
                                                   input logic [FIELD_W-1:0] max_value,
                                                   input logic               up);
    logic [FIELD_W-1:0] result;
    if (up) begin
      result = (value >= max_value) ? FIELD_W'(0) : value + FIELD_W'(1);
    end else begin
      result = ((value == FIELD_W'(0)) || (value > max_value)) ? max_value : value - FIELD_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/clock_time_setter_button_step.sv
// Rising-edge step pulse for one up/down button, with hold-to-repeat when
// CLOCK_SETTER_AUTOREPEAT_EN is defined.
module button_step #(
  parameter int unsigned REPEAT_DELAY  = 32'd500000,
  parameter int unsigned REPEAT_PERIOD = 32'd100000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
  input  logic hold_en,
`endif
  output logic step_c
);

  logic btn_q;
  logic edge_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign edge_c = btn & ~btn_q;

`ifdef CLOCK_SETTER_AUTOREPEAT_EN
  logic [31:0] hold_cnt;
  logic        holding_c;
  logic        repeat_c;

  assign holding_c = hold_en & btn;
  assign repeat_c  = holding_c && (hold_cnt == 32'(REPEAT_DELAY));

  // After the first repeat, reload so the next one lands REPEAT_PERIOD cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (!holding_c) begin
      hold_cnt <= '0;
    end else if (repeat_c) begin
      hold_cnt <= 32'(REPEAT_DELAY - REPEAT_PERIOD + 32'd1);
    end else begin
      hold_cnt <= hold_cnt + 32'd1;
    end
  end

  assign step_c = edge_c | repeat_c;
`else
  assign step_c = edge_c;
`endif

endmodule

// File: rtl/clock_time_setter.sv
// Button-driven time-set controller feeding the 24-hour clock counter.
// Optional hold-to-repeat on up/down: define CLOCK_SETTER_AUTOREPEAT_EN.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1000000,
  parameter int unsigned REPEAT_DELAY   = 32'd500000,
  parameter int unsigned REPEAT_PERIOD  = 32'd100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_mode,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic [HOURS_W-1:0]   cur_hours,
  input  logic [MINUTES_W-1:0] cur_minutes,
  output logic [HOURS_W-1:0]   in_hours,
  output logic [MINUTES_W-1:0] in_minutes,
  output logic                 propagate,
  output logic                 editing,
  output logic                 edit_field
);

  setter_state_t        state;
  setter_state_t        next_state;
  logic                 mode_q;
  logic                 mode_evt;
  logic                 up_step_c;
  logic                 down_step_c;
  logic                 any_evt;
  logic                 inc_c;
  logic                 dec_c;
  logic                 timeout_hit;
  logic [31:0]          tmo_cnt;
  logic [31:0]          tmo_cnt_next;
  logic [HOURS_W-1:0]   hours_next;
  logic [MINUTES_W-1:0] minutes_next;

  assign mode_evt    = btn_mode & ~mode_q;
  assign any_evt     = mode_evt | up_step_c | down_step_c;
  assign inc_c       = up_step_c & ~down_step_c & ~mode_evt;
  assign dec_c       = down_step_c & ~up_step_c & ~mode_evt;
  assign timeout_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 32'd1));

`ifdef CLOCK_SETTER_AUTOREPEAT_EN
  logic in_edit;
  logic up_hold_en;
  logic down_hold_en;

  // Repeat only while a single button is held and the state is not about to change.
  assign in_edit      = (state == EDIT_HOUR) || (state == EDIT_MIN);
  assign up_hold_en   = in_edit & ~btn_down & ~mode_evt & ~timeout_hit;
  assign down_hold_en = in_edit & ~btn_up & ~mode_evt & ~timeout_hit;
`endif

  button_step #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_up_step (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_up),
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
    .hold_en(up_hold_en),
`endif
    .step_c (up_step_c)
  );

  button_step #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_down_step (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_down),
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
    .hold_en(down_hold_en),
`endif
    .step_c (down_step_c)
  );

  // Next state, edited fields and idle-timeout count.
  always_comb begin
    next_state   = state;
    hours_next   = in_hours;
    minutes_next = in_minutes;
    tmo_cnt_next = '0;
    case (state)
      IDLE: begin
        if (mode_evt) begin
          hours_next   = cur_hours;
          minutes_next = cur_minutes;
          next_state   = EDIT_HOUR;
        end
      end
      EDIT_HOUR, EDIT_MIN: begin
        if (mode_evt) begin
          next_state = (state == EDIT_HOUR) ? EDIT_MIN : COMMIT;
        end else if (any_evt) begin
          if (inc_c || dec_c) begin
            if (state == EDIT_HOUR) begin
              hours_next = HOURS_W'(wrap_step(FIELD_W'(in_hours), FIELD_W'(MAX_HOUR), inc_c));
            end else begin
              minutes_next = MINUTES_W'(wrap_step(FIELD_W'(in_minutes), FIELD_W'(MAX_MINUTE), inc_c));
            end
          end
        end else if (timeout_hit) begin
          next_state = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + 32'd1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      tmo_cnt    <= '0;
      in_hours   <= '0;
      in_minutes <= '0;
      propagate  <= 1'b0;
      editing    <= 1'b0;
      edit_field <= 1'b0;
    end else begin
      state      <= next_state;
      mode_q     <= btn_mode;
      tmo_cnt    <= tmo_cnt_next;
      in_hours   <= hours_next;
      in_minutes <= minutes_next;
      propagate  <= (next_state == COMMIT);
      editing    <= (next_state == EDIT_HOUR) || (next_state == EDIT_MIN);
      edit_field <= (next_state == EDIT_MIN);
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Randomized and directed self-checking bench for clock_time_setter against a behavioural model.
module tb_clock_time_setter;

  localparam int TMO = 16;
  localparam int RD  = 8;
  localparam int RP  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [4:0] cur_hours = 5'd0;
  logic [5:0] cur_minutes = 6'd0;
  logic [4:0] in_hours;
  logic [5:0] in_minutes;
  logic       propagate;
  logic       editing;
  logic       edit_field;

  int checks = 0;
  int errors = 0;

  clock_time_setter #(
    .TIMEOUT_CYCLES(TMO),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .cur_hours  (cur_hours),
    .cur_minutes(cur_minutes),
    .in_hours   (in_hours),
    .in_minutes (in_minutes),
    .propagate  (propagate),
    .editing    (editing),
    .edit_field (edit_field)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time-set session as a handful of flags and integers.
  int m_h = 0, m_m = 0, quiet = 0;
  bit m_edit = 0, m_field = 0, m_prop = 0;
  bit pm = 0, pu = 0, pd = 0;
  bit ev_m, ev_u, ev_d;
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
  int ku = 0, kd = 0;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_h = 0; m_m = 0; quiet = 0;
      m_edit = 0; m_field = 0; m_prop = 0;
      pm = 0; pu = 0; pd = 0;
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
      ku = 0; kd = 0;
`endif
    end else begin
      ev_m = btn_mode && !pm;
      ev_u = btn_up && !pu;
      ev_d = btn_down && !pd;
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
      if (m_edit && btn_up && !btn_down && !ev_m && quiet != TMO - 1) begin
        if (ku >= RD && (ku - RD) % RP == 0) ev_u = 1;
        ku++;
      end else ku = 0;
      if (m_edit && btn_down && !btn_up && !ev_m && quiet != TMO - 1) begin
        if (kd >= RD && (kd - RD) % RP == 0) ev_d = 1;
        kd++;
      end else kd = 0;
`endif
      pm = btn_mode; pu = btn_up; pd = btn_down;
      if (m_prop) begin
        m_prop = 0;
      end else if (!m_edit) begin
        if (ev_m) begin
          m_h = cur_hours; m_m = cur_minutes;
          m_edit = 1; m_field = 0; quiet = 0;
        end
      end else if (ev_m) begin
        quiet = 0;
        if (m_field) begin
          m_edit = 0; m_field = 0; m_prop = 1;
        end else m_field = 1;
      end else if (ev_u || ev_d) begin
        quiet = 0;
        if (ev_u != ev_d) begin
          if (!m_field) begin
            if (ev_u) m_h = (m_h < 23) ? (m_h + 1) % 24 : 0;
            else      m_h = (m_h >= 1 && m_h <= 23) ? m_h - 1 : 23;
          end else begin
            if (ev_u) m_m = (m_m < 59) ? (m_m + 1) % 60 : 0;
            else      m_m = (m_m >= 1 && m_m <= 59) ? m_m - 1 : 59;
          end
        end
      end else if (quiet == TMO - 1) begin
        quiet = 0; m_edit = 0; m_field = 0;
      end else begin
        quiet++;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("model_hours", int'(in_hours), m_h);
    chk("model_minutes", int'(in_minutes), m_m);
    chk("model_propagate", int'(propagate), int'(m_prop));
    chk("model_editing", int'(editing), int'(m_edit));
    chk("model_edit_field", int'(edit_field), int'(m_field));
  end

  // Called at a negedge: one idle sample, then the buttons for one sample; returns after that edge.
  task automatic step(input logic m, input logic u, input logic d);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d;
    @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic chk_outputs(input string name, input int h, input int mi, input int p, input int e, input int f);
    chk({name, "_hours"}, int'(in_hours), h);
    chk({name, "_minutes"}, int'(in_minutes), mi);
    chk({name, "_propagate"}, int'(propagate), p);
    chk({name, "_editing"}, int'(editing), e);
    chk({name, "_edit_field"}, int'(edit_field), f);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_outputs("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    cur_hours = 5'd12; cur_minutes = 6'd34;
    step(1, 0, 0);
    chk_outputs("enter", 12, 34, 0, 1, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 0);
    chk("hours_at_23", int'(in_hours), 23);
    step(0, 1, 0);
    chk("hours_wrap_up", int'(in_hours), 0);
    step(0, 0, 1);
    chk("hours_wrap_down", int'(in_hours), 23);
    step(0, 0, 1);
    chk("hours_22", int'(in_hours), 22);
    step(1, 0, 0);
    chk("field_minutes", int'(edit_field), 1);
    for (int i = 0; i < 25; i++) step(0, 1, 0);
    chk("minutes_at_59", int'(in_minutes), 59);
    step(0, 1, 0);
    chk("minutes_wrap_up", int'(in_minutes), 0);
    step(0, 0, 1);
    chk("minutes_wrap_down", int'(in_minutes), 59);
    step(1, 0, 0);
    chk_outputs("commit", 22, 59, 1, 0, 0);
    @(negedge clk);
    chk_outputs("after_commit", 22, 59, 0, 0, 0);

    // Abandon by inactivity from EDIT_HOUR.
    cur_hours = 5'd5; cur_minutes = 6'd0;
    step(1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("timeout_no_prop", int'(propagate), 0);
    end
    chk("timeout_still_editing", int'(editing), 1);
    @(negedge clk);
    chk_outputs("timeout_idle", 5, 0, 0, 0, 0);
    @(negedge clk);
    chk("timeout_after_prop", int'(propagate), 0);

    cur_minutes = 6'd7;
    step(1, 0, 0);
    step(1, 1, 0);
    chk_outputs("mode_beats_up", 5, 7, 0, 1, 1);
    step(0, 1, 1);
    chk("up_down_ignored", int'(in_minutes), 7);

    // Asynchronous reset in the middle of EDIT_MIN.
    #2 reset = 1'b1;
    #1 chk_outputs("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    cur_hours = 5'd3; cur_minutes = 6'd10;
    step(1, 0, 0);
    step(1, 0, 0);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (20) @(negedge clk);
    btn_up = 1'b0;
`ifdef CLOCK_SETTER_AUTOREPEAT_EN
    chk("hold_up_minutes", int'(in_minutes), 14);
`else
    chk("hold_up_minutes", int'(in_minutes), 11);
`endif

    // Random phase, including out-of-range cur_* values and quiet stretches.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 300 >= 280) begin
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      end else begin
        btn_mode = ($urandom_range(0, 7) == 0);
        btn_up   = ($urandom_range(0, 2) == 0);
        btn_down = ($urandom_range(0, 3) == 0);
      end
      cur_hours   = 5'($urandom_range(0, 31));
      cur_minutes = 6'($urandom_range(0, 63));
    end
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
